gshare_predictor: RTL and testbench

- Parametrised correlating branch predictor and successor to the two-table, 1-bit-history BHT scheme.
- Keeps a HIST_W-bit global history register (GHR) and one table of CTR_W-bit saturating counters, indexed by PC bits combined with GHR, either concatenated or XORed.
- Predicts on request with a registered response and trains on resolved outcomes.
- Clears its table with a post-reset sweep and counts mispredictions.

---
 rtl/gshare_predictor.sv | 152 +++++++++++++++
 tb/tb_gshare_predictor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare branch predictor: global history + one table of saturating counters, PC/GHR index by concat or XOR.
// Latency: prediction response registered, 1 cycle after an accepted request; updates take effect on the same edge.
// Backpressure: none in RUN (one request/update per cycle); while ready=0 (init sweep) requests and updates are dropped.
module gshare_predictor #(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 10,
    parameter int HIST_W = 2,
    parameter int CTR_W  = 2,
    parameter int MODE   = 1,
    parameter int MISS_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_pc,
    output logic              pred_out_valid,
    output logic              pred_taken,
    output logic [CTR_W-1:0]  pred_ctr,
    output logic [IDX_W-1:0]  pred_index,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_index,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [MISS_W-1:0] miss_count,
    output logic [HIST_W-1:0] ghr
);

    localparam int DEPTH = 2 ** IDX_W;
    // Weakly-not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_W-1:0] WNT = {1'b0, {(CTR_W-1){1'b1}}};

    typedef enum logic {INIT, RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_ptr;
    logic [CTR_W-1:0]  r_tab [DEPTH];
    logic [HIST_W-1:0] r_ghr;
    logic [MISS_W-1:0] r_miss;
    logic              r_ovld;
    logic              r_taken;
    logic [CTR_W-1:0]  r_ctr;
    logic [IDX_W-1:0]  r_idx;

    logic              w_run;
    logic              w_pred_acc;
    logic              w_upd_acc;
    logic [IDX_W-1:0]  w_idx;
    logic [CTR_W-1:0]  w_upd_old;
    logic [CTR_W-1:0]  w_upd_new;
    // Upper PC bits are deliberately not part of the index.
    logic              w_unused_pc;

    assign w_unused_pc = ^pred_pc;
    assign w_run       = (r_state == RUN);
    assign w_pred_acc  = w_run && pred_valid;
    assign w_upd_acc   = w_run && upd_valid;

    // Index function selected at elaboration; always uses the pre-update history.
    generate
        if (MODE == 0) begin : g_concat
            if (HIST_W == IDX_W) begin : g_hist_only
                assign w_idx = r_ghr;
            end else begin : g_hist_pc
                assign w_idx = {r_ghr, pred_pc[IDX_W-HIST_W-1:0]};
            end
        end else begin : g_xor
            logic [IDX_W-1:0] w_ghr_ext;
            // Zero-extend history to index width before folding into the PC.
            always_comb begin
                w_ghr_ext             = '0;
                w_ghr_ext[HIST_W-1:0] = r_ghr;
            end
            assign w_idx = pred_pc[IDX_W-1:0] ^ w_ghr_ext;
        end
    endgenerate

    // State register: INIT sweeps the table, RUN serves traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= INIT;
        else     r_state <= w_state_nxt;
    end

    // Leave INIT once the last entry has been written.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_ptr == '1) w_state_nxt = RUN;
    end

    // Sweep pointer walks every entry exactly once after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_ptr <= '0;
        else if (r_state == INIT) r_ptr <= r_ptr + IDX_W'(1);
    end

    // Saturating step of the counter being trained.
    always_comb begin
        w_upd_old = r_tab[upd_index];
        w_upd_new = w_upd_old;
        if (upd_taken) begin
            if (w_upd_old != '1) w_upd_new = w_upd_old + CTR_W'(1);
        end else begin
            if (w_upd_old != '0) w_upd_new = w_upd_old - CTR_W'(1);
        end
    end

    // Counter table: sweep writes in INIT, training writes in RUN (read-before-write on collisions).
    always_ff @(posedge clk) begin
        if (r_state == INIT) r_tab[r_ptr]     <= WNT;
        else if (upd_valid)  r_tab[upd_index] <= w_upd_new;
    end

    // Non-speculative history: shifts in the resolved outcome only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_ghr <= '0;
        else if (w_upd_acc) r_ghr <= (r_ghr << 1) | HIST_W'(upd_taken);
    end

    // Mispredict counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_miss <= '0;
        else if (w_upd_acc && (upd_pred != upd_taken) && (r_miss != '1))
            r_miss <= r_miss + MISS_W'(1);
    end

    // Registered prediction response; payload holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovld  <= 1'b0;
            r_taken <= 1'b0;
            r_ctr   <= '0;
            r_idx   <= '0;
        end else begin
            r_ovld <= w_pred_acc;
            if (w_pred_acc) begin
                r_idx   <= w_idx;
                r_ctr   <= r_tab[w_idx];
                r_taken <= r_tab[w_idx][CTR_W-1];
            end
        end
    end

    assign ready          = w_run;
    assign pred_out_valid = r_ovld;
    assign pred_taken     = r_taken;
    assign pred_ctr       = r_ctr;
    assign pred_index     = r_idx;
    assign miss_count     = r_miss;
    assign ghr            = r_ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: XOR-indexed and concat-indexed instances share stimulus.
// A table/history/miss model predicts every response; directed steps then random traffic.
// Both instances use IDX_W=4, HIST_W=2, CTR_W=2, MISS_W=2.
module tb_gshare_predictor;

    logic       clk = 1'b0;
    logic       rst;
    logic       pred_valid;
    logic [9:0] pred_pc;
    logic       upd_valid;
    logic [3:0] upd_index_x, upd_index_c;
    logic       upd_taken, upd_pred;

    logic       ready_x, ovld_x, taken_x, ready_c, ovld_c, taken_c;
    logic [1:0] ctr_x, ctr_c, miss_x, miss_c, ghr_x, ghr_c;
    logic [3:0] idx_x, idx_c;

    always #5 clk = ~clk;

    gshare_predictor #(.ADDR_W(10), .IDX_W(4), .HIST_W(2), .CTR_W(2), .MODE(1), .MISS_W(2)) u_x (
        .clk(clk), .rst(rst), .ready(ready_x),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(ovld_x), .pred_taken(taken_x), .pred_ctr(ctr_x), .pred_index(idx_x),
        .upd_valid(upd_valid), .upd_index(upd_index_x), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .miss_count(miss_x), .ghr(ghr_x)
    );

    gshare_predictor #(.ADDR_W(10), .IDX_W(4), .HIST_W(2), .CTR_W(2), .MODE(0), .MISS_W(2)) u_c (
        .clk(clk), .rst(rst), .ready(ready_c),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(ovld_c), .pred_taken(taken_c), .pred_ctr(ctr_c), .pred_index(idx_c),
        .upd_valid(upd_valid), .upd_index(upd_index_c), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .miss_count(miss_c), .ghr(ghr_c)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference state: [0] = XOR instance, [1] = concat instance.
    int mtab [2][16];
    int mghr;
    int mmiss;
    int e_vld;
    int e_ctr [2];
    int e_idx [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input int k, input int pc, input int g);
        if (k == 0) return (pc % 16) ^ g;
        return g * 4 + (pc % 4);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mtab[k][i] = 1;
            e_ctr[k] = 0;
            e_idx[k] = 0;
        end
        mghr  = 0;
        mmiss = 0;
        e_vld = 0;
    endtask

    task automatic check_outputs();
        chk("vld_x",   ovld_x,  e_vld);
        chk("vld_c",   ovld_c,  e_vld);
        chk("ctr_x",   ctr_x,   e_ctr[0]);
        chk("ctr_c",   ctr_c,   e_ctr[1]);
        chk("taken_x", taken_x, (e_ctr[0] >= 2) ? 1 : 0);
        chk("taken_c", taken_c, (e_ctr[1] >= 2) ? 1 : 0);
        chk("idx_x",   idx_x,   e_idx[0]);
        chk("idx_c",   idx_c,   e_idx[1]);
        chk("ghr_x",   ghr_x,   mghr);
        chk("ghr_c",   ghr_c,   mghr);
        chk("miss_x",  miss_x,  mmiss);
        chk("miss_c",  miss_c,  mmiss);
    endtask

    // One clock in RUN: drive, advance the model (reads before writes), tick, compare.
    task automatic cycle(input bit pv, input int pc, input bit uv, input int ux, input int uc,
                         input bit ut, input bit up);
        int ui [2];
        pred_valid  = pv;
        pred_pc     = pc[9:0];
        upd_valid   = uv;
        upd_index_x = ux[3:0];
        upd_index_c = uc[3:0];
        upd_taken   = ut;
        upd_pred    = up;
        e_vld = pv;
        if (pv) begin
            for (int k = 0; k < 2; k++) begin
                e_idx[k] = midx(k, pc, mghr);
                e_ctr[k] = mtab[k][e_idx[k]];
            end
        end
        if (uv) begin
            ui[0] = ux;
            ui[1] = uc;
            for (int k = 0; k < 2; k++) begin
                if (ut) mtab[k][ui[k]] = (mtab[k][ui[k]] == 3) ? 3 : mtab[k][ui[k]] + 1;
                else    mtab[k][ui[k]] = (mtab[k][ui[k]] == 0) ? 0 : mtab[k][ui[k]] - 1;
            end
            mghr = (mghr * 2 + (ut ? 1 : 0)) % 4;
            if (up != ut && mmiss < 3) mmiss++;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Count cycles until both instances raise ready; requests must stay ignored meanwhile.
    task automatic wait_sweep(input string tag);
        int n = 0;
        while (!(ready_x && ready_c) && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            chk({tag, "_novld_x"}, ovld_x, 0);
            chk({tag, "_novld_c"}, ovld_c, 0);
        end
        chk({tag, "_len"}, n, 16);
        chk({tag, "_ghr0"}, ghr_x, 0);
        chk({tag, "_miss0"}, miss_c, 0);
    endtask

    initial begin
        int exp_miss [5];
        bit ut;
        exp_miss = '{1, 2, 3, 3, 3};
        rst = 1'b0; pred_valid = 0; pred_pc = '0; upd_valid = 0;
        upd_index_x = '0; upd_index_c = '0; upd_taken = 0; upd_pred = 0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state.
        chk("rst_ready", ready_x, 0);
        chk("rst_vld",   ovld_x,  0);
        chk("rst_ctr",   ctr_x,   0);
        chk("rst_idx",   idx_c,   0);
        chk("rst_ghr",   ghr_x,   0);
        chk("rst_miss",  miss_x,  0);

        // Sweep with traffic held active; restart it at cycle 7.
        pred_valid = 1; upd_valid = 1; upd_taken = 1; upd_pred = 0; pred_pc = 10'h0F0;
        rst = 1'b0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
            chk("init_ready", ready_x, 0);
            chk("init_novld", ovld_x, 0);
        end
        rst = 1'b1;
        #1 chk("restart_ready", ready_x, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_sweep("sweep1");
        pred_valid = 0; upd_valid = 0;
        model_reset();

        // Every entry reads weakly-not-taken after the sweep (upper pc bits vary).
        for (int p = 0; p < 16; p++) begin
            cycle(1, p + 16 * $urandom_range(0, 63), 0, 0, 0, 0, 0);
            chk("init_ctr_x", ctr_x, 1);
            chk("init_ctr_c", ctr_c, 1);
        end

        // Same-edge predict and update of idx 5: prediction sees the old value.
        cycle(1, 5, 1, 5, 5, 1, 1);
        chk("coll_old", ctr_x, 1);
        cycle(1, 4, 0, 0, 0, 0, 0);  // ghr=01, 4^1=5
        chk("coll_new", ctr_x, 2);

        // Saturation at idx 0 (XOR instance predicts pc=ghr -> idx 0).
        for (int i = 0; i < 3; i++) cycle(1, mghr, 1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, mghr, 1, 0, 0, 0, 0);
            if (i == 0) chk("sat_hi", ctr_x, 3);
        end
        cycle(1, mghr, 0, 0, 0, 0, 0);
        chk("sat_lo", ctr_x, 0);
        chk("sat_lo_taken", taken_x, 0);

        // Mispredict counter saturates at 3 with MISS_W=2.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 15, 15, 1, 0);
            chk("miss_step", miss_x, exp_miss[i]);
        end
        cycle(0, 0, 1, 15, 15, 0, 0);
        chk("miss_hold", miss_x, 3);

        // History correlation on the concat instance: T,N pattern becomes perfectly predicted.
        for (int i = 0; i < 8; i++) begin
            ut = (i % 2 == 0);
            cycle(1, 'h0F0, 0, 0, 0, 0, 0);
            if (i >= 4) chk("corr_pred", taken_c, ut);
            cycle(0, 0, 1, e_idx[0], e_idx[1], ut, e_ctr[1] >= 2);
        end

        // Reset in mid-operation clears everything immediately and restarts the sweep.
        pred_valid = 1;
        rst = 1'b1;
        #1;
        chk("mid_ready", ready_c, 0);
        chk("mid_vld",   ovld_x,  0);
        chk("mid_ctr",   ctr_c,   0);
        chk("mid_idx",   idx_x,   0);
        chk("mid_ghr",   ghr_c,   0);
        chk("mid_miss",  miss_x,  0);
        pred_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        wait_sweep("sweep2");
        model_reset();

        // Random traffic against the model.
        repeat (400) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
